// File: rtl/sram_stream_reader.sv
// Streams a contiguous SRAM row range out as valid/ready words through a 2-entry skid buffer.
// Defining SRAM_READER_ABORT_EN adds an abort input that cancels a running transfer.
module sram_stream_reader #(
  parameter int WIDTH = 128,
  parameter int NUM_ROWS = 4096,
  localparam int ADDRESS_WIDTH = $clog2(NUM_ROWS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
`ifdef SRAM_READER_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     sram_REB,
  output logic [ADDRESS_WIDTH-1:0] sram_AB,
  input  logic [WIDTH-1:0]         sram_Q,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_READ  | issuing SRAM reads while buffer space allows
  // S_DRAIN | all reads issued, emptying buffer and inflight word
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ROW = ADDRESS_WIDTH'(NUM_ROWS - 1);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH:0]   remaining;
  logic                     inflight;
  logic [WIDTH-1:0]         skid [2];
  logic                     rd_ptr;
  logic                     wr_ptr;
  logic [1:0]               count;
  logic [1:0]               occ;
  logic                     pop;
  logic                     buf_pop;
  logic                     push;
  logic                     abort_now;

`ifdef SRAM_READER_ABORT_EN
  assign abort_now = abort && ((state == S_READ) || (state == S_DRAIN));
`else
  assign abort_now = 1'b0;
`endif

  // The word in flight is presented straight from sram_Q while the buffer is empty,
  // which gives first data one cycle after the first read.
  assign out_valid = (count != 2'd0) || inflight;
  assign out_data  = (count != 2'd0) ? skid[rd_ptr] : (inflight ? sram_Q : '0);

  assign occ     = count + {1'b0, inflight};
  assign pop     = out_valid && out_ready;
  assign buf_pop = pop && (count != 2'd0);
  assign push    = inflight && !((count == 2'd0) && pop);

  assign sram_REB = (state == S_READ) && (remaining != '0) && !abort_now &&
                    ((occ < 2'd2) || pop);
  assign sram_AB  = addr;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      skid[0]   <= '0;
      skid[1]   <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else if (abort_now) begin
      state     <= S_DONE;
      remaining <= '0;
      inflight  <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      inflight <= sram_REB;
      if (push) begin
        skid[wr_ptr] <= sram_Q;
        wr_ptr       <= ~wr_ptr;
      end
      if (buf_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, buf_pop};

      if (sram_REB) begin
        addr      <= (addr == LAST_ROW) ? '0 : addr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= length;
            state     <= (length == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (sram_REB && (remaining == (ADDRESS_WIDTH+1)'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && (occ == 2'd1)) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side master for the generic double-port SRAM macro.
- Walks a contiguous address range on the SRAM read port and presents each row as a valid/ready stream word.
- Absorbs the 1-cycle synchronous read latency and downstream backpressure with a 2-entry skid buffer.
- Sits between SRAM banks and consumers such as neuron cores or DMA-out.

Parameters:
- WIDTH, 128: data width, matches the SRAM WIDTH.
- NUM_ROWS, 4096: SRAM depth.
- ADDRESS_WIDTH, $clog2(NUM_ROWS): localparam, address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  begin a transfer; sampled only in IDLE.
- base_addr  in  ADDRESS_WIDTH  first row, sampled with start.
- length  in  ADDRESS_WIDTH+1  number of rows, 0..NUM_ROWS, sampled with start.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse at transfer completion.
- sram_REB  out  1  to SRAM REB, active high.
- sram_AB  out  ADDRESS_WIDTH  to SRAM AB.
- sram_Q  in  WIDTH  from SRAM Q.
- out_data  out  WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.

Behaviour:
- Reset: busy=0, done=0, sram_REB=0, sram_AB=0, out_valid=0, out_data=0. FSM to IDLE; counters, inflight flag and buffer cleared. Reset mid-transfer abandons it with no done pulse.
- States:
  - IDLE: start=1 and length>0 -> READ. start=1 and length=0 -> DONE. Otherwise stay.
  - READ: issuing reads. The cycle the last read issues -> DRAIN.
  - DRAIN: no new reads. On the cycle the last word is accepted (out_valid&out_ready) -> DONE.
  - DONE: one cycle, done=1, then IDLE.
- start while busy is ignored.
- Issue rule: sram_REB=1 in READ when remaining>0 and (buf_count + inflight) < 2, or ==2 with a pop this cycle.
  - This creates a combinational path out_ready -> sram_REB.
  - sram_AB = current address.
- Capture: inflight is set on the cycle after REB=1. sram_Q is pushed into the buffer in that cycle. Q is never captured otherwise; the SRAM holds Q when REB=0.
- Buffer: 2-entry FIFO, out_data/out_valid driven from its head. It must never overflow and must never drop or duplicate a word.
- Address: increments by 1 per issued read. Wraps from NUM_ROWS-1 to 0, including non-power-of-two NUM_ROWS.
- Latency: start sampled at edge t -> first REB in cycle t+1 -> first out_valid in cycle t+2.
- Throughput: with out_ready held high, 1 word/cycle. length=N completes with done in cycle t+N+2 (last word accepted in t+N+1).
- Words are emitted in address order. out_data is stable while out_valid=1 and out_ready=0.
- length=NUM_ROWS reads every row exactly once.

Optional Feature:
- Macro: SRAM_READER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in READ or DRAIN: stop issuing, discard buffer contents and any inflight result, drop out_valid next cycle. Go to DONE (done pulses), then IDLE.
  - abort in IDLE/DONE has no effect.
  - abort takes priority over a simultaneous out_valid&out_ready on the last word; done pulses once.
- Undefined: no abort port; transfers always run to completion.

Test Plan:
- Reset: assert RST asynchronously mid-cycle -> all outputs 0 immediately, busy=0; after release, start works normally.
- Streaming: SRAM rows 10..13 = 0xA0..0xA3, start with base=10, length=4, out_ready=1 -> sram_REB high t+1..t+4 with AB=10..13; out_valid t+2..t+5 with data A0..A3; done=1 at t+6.
- Backpressure: length=8, out_ready toggled in a random pattern -> exactly 8 words in order. buf_count+inflight never exceeds 2, no REB issued while full without a pop, out_data stable while stalled.
- Wrap and zero length:
  - NUM_ROWS=4096, base=4094, length=4 -> AB sequence 4094, 4095, 0, 1.
  - length=0 -> no REB; done at t+1; busy for that cycle only.
- Start while busy and reset mid-transfer: start pulsed during READ -> ignored, transfer unchanged. RST during DRAIN -> no done; new transfer after reset correct.
- Abort (SRAM_READER_ABORT_EN): length=16, abort at the 5th accepted word with out_ready=1 -> no further REB, out_valid low next cycle, single done pulse, IDLE after.
